// File: rtl/apb_mem_pkg.sv
// Shared types and helpers for the APB register-file slave (apb_mem_slave).
package apb_mem_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } apb_state_e;

    localparam int WAIT_W = 4;

    // Flags a byte address that is not word aligned or lies past the last word.
    function automatic logic addr_err(input logic [31:0] paddr, input int depth, input int lb);
        logic [31:0] w_mask;
        w_mask = (32'd1 << lb) - 32'd1;
        return ((paddr & w_mask) != 32'd0) || ((paddr >> lb) >= 32'(depth));
    endfunction

endpackage

// File: rtl/apb_wait_ctrl.sv
// Transfer FSM for apb_mem_slave: setup/access sequencing, wait-state counter,
// PREADY/PSLVERR generation and the write-commit / read-load strobes.
module apb_wait_ctrl
    import apb_mem_pkg::*;
#(
    parameter int WAIT_CYCLES = 0
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_psel,
    input  logic i_penable,
    input  logic i_write,
    input  logic i_err,
    output logic o_setup,
    output logic o_pready,
    output logic o_pslverr,
    output logic o_wr_commit,
    output logic o_rd_load,
    output logic o_rd_err
);

    apb_state_e        r_state;
    apb_state_e        w_state_nxt;
    logic [WAIT_W-1:0] r_cnt;
    logic [WAIT_W-1:0] w_cnt_nxt;
    logic              r_write;
    logic              r_err;
    logic              w_setup;
    logic              w_xfer;

    // A setup phase is accepted in any state, so an abort with a new setup restarts cleanly.
    assign w_setup = i_psel & ~i_penable;
    assign w_xfer  = i_psel & i_penable;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_write <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_setup) begin
                r_write <= i_write;
                r_err   <= i_err;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        if (w_setup) begin
            w_state_nxt = ACCESS;
            w_cnt_nxt   = WAIT_W'(WAIT_CYCLES);
        end else if (r_state == ACCESS) begin
            if (!w_xfer || (r_cnt == '0)) begin
                w_state_nxt = IDLE;
            end else begin
                w_cnt_nxt = r_cnt - WAIT_W'(1);
            end
        end
    end

    always_comb begin
        o_setup     = w_setup;
        o_pready    = (r_state == ACCESS) && (r_cnt == '0);
        o_pslverr   = o_pready & r_err;
        o_wr_commit = o_pready & w_xfer & r_write & ~r_err;
        o_rd_load   = 1'b0;
        o_rd_err    = r_err;
        // Read data is loaded on the edge that raises PREADY.
        if (WAIT_CYCLES == 0) begin
            o_rd_load = w_setup & ~i_write;
            o_rd_err  = i_err;
        end else begin
            o_rd_load = (r_state == ACCESS) && w_xfer && (r_cnt == WAIT_W'(1)) && !r_write;
        end
    end

endmodule

// File: rtl/apb_mem_slave.sv
// APB slave backed by a byte-lane register file with configurable wait states.
// Define APB_MEM_PSTRB_EN to add the PSTRB port and per-lane write strobes.
module apb_mem_slave
    import apb_mem_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 8,
    parameter int DEPTH       = 16,
    parameter int WAIT_CYCLES = 0
) (
    input  logic              PCLK,
    input  logic              PRESETn,
    input  logic              PSEL,
    input  logic              PENABLE,
    input  logic              PWRITE,
    input  logic [ADDR_W-1:0] PADDR,
    input  logic [DATA_W-1:0] PWDATA,
`ifdef APB_MEM_PSTRB_EN
    input  logic [DATA_W/8-1:0] PSTRB,
`endif
    output logic [DATA_W-1:0] PRDATA,
    output logic              PREADY,
    output logic              PSLVERR
);

    localparam int NB    = DATA_W / 8;
    localparam int LB    = $clog2(NB);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [IDX_W-1:0]    w_idx;
    logic [IDX_W-1:0]    r_idx;
    logic [IDX_W-1:0]    w_rd_idx;
    logic                w_err;
    logic [NB-1:0]       w_lane_we;
    logic [NB-1:0][7:0]  w_rd_word;
    logic [DATA_W-1:0]   r_prdata;
    logic                w_setup;
    logic                w_wr_commit;
    logic                w_rd_load;
    logic                w_rd_err;

    assign w_idx = IDX_W'(PADDR >> LB);

`ifdef APB_MEM_PSTRB_EN
    // A read must not carry strobes; a write only touches the strobed lanes.
    assign w_err     = addr_err(32'(PADDR), DEPTH, LB) | (~PWRITE & (|PSTRB));
    assign w_lane_we = PSTRB;
`else
    assign w_err     = addr_err(32'(PADDR), DEPTH, LB);
    assign w_lane_we = '1;
`endif

    apb_wait_ctrl #(
        .WAIT_CYCLES(WAIT_CYCLES)
    ) u_wait_ctrl (
        .i_clk      (PCLK),
        .i_rst_n    (PRESETn),
        .i_psel     (PSEL),
        .i_penable  (PENABLE),
        .i_write    (PWRITE),
        .i_err      (w_err),
        .o_setup    (w_setup),
        .o_pready   (PREADY),
        .o_pslverr  (PSLVERR),
        .o_wr_commit(w_wr_commit),
        .o_rd_load  (w_rd_load),
        .o_rd_err   (w_rd_err)
    );

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_idx <= '0;
        end else if (w_setup) begin
            r_idx <= w_idx;
        end
    end

    // With no wait states the read happens on the setup edge, before r_idx is loaded.
    assign w_rd_idx = (WAIT_CYCLES == 0) ? w_idx : r_idx;

    for (genvar g = 0; g < NB; g++) begin : g_lane
        logic [7:0] r_lane [DEPTH];

        always_ff @(posedge PCLK or negedge PRESETn) begin
            if (!PRESETn) begin
                for (int i = 0; i < DEPTH; i++) begin
                    r_lane[i] <= '0;
                end
            end else if (w_wr_commit && w_lane_we[g]) begin
                r_lane[r_idx] <= PWDATA[g*8 +: 8];
            end
        end

        assign w_rd_word[g] = r_lane[w_rd_idx];
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_prdata <= '0;
        end else if (w_rd_load) begin
            r_prdata <= w_rd_err ? '0 : w_rd_word;
        end
    end

    assign PRDATA = r_prdata;

endmodule

// File: tb/tb_apb_mem_slave.sv
// Bench for apb_mem_slave: three instances (0, 2 and 3 wait states) on separate buses.
module tb_apb_mem_slave;

    localparam int N     = 3;
    localparam int DEPTH = 16;
    localparam int TMO   = 40;

    logic        PCLK = 1'b0;
    logic        PRESETn;
    logic        psel    [N];
    logic        penable [N];
    logic        pwrite  [N];
    logic [7:0]  paddr   [N];
    logic [31:0] pwdata  [N];
    logic [3:0]  pstrb   [N];
    logic [31:0] prdata  [N];
    logic        pready  [N];
    logic        pslverr [N];

    int n_vec = 0;
    int n_err = 0;

    logic [31:0] mdl_mem [N][DEPTH];
    logic [31:0] mdl_prd [N];

    typedef struct {
        int          k;
        logic        wr;
        logic [7:0]  a;
        logic [31:0] d;
        logic [3:0]  s;
        logic        err;
        logic [31:0] rd;
    } vec_t;

    vec_t tbl [12];

    always #5 PCLK = ~PCLK;

    for (genvar g = 0; g < N; g++) begin : g_dut
        apb_mem_slave #(
            .DATA_W(32), .ADDR_W(8), .DEPTH(DEPTH),
            .WAIT_CYCLES((g == 0) ? 0 : ((g == 1) ? 2 : 3))
        ) u_dut (
            .PCLK   (PCLK),
            .PRESETn(PRESETn),
            .PSEL   (psel[g]),
            .PENABLE(penable[g]),
            .PWRITE (pwrite[g]),
            .PADDR  (paddr[g]),
            .PWDATA (pwdata[g]),
`ifdef APB_MEM_PSTRB_EN
            .PSTRB  (pstrb[g]),
`endif
            .PRDATA (prdata[g]),
            .PREADY (pready[g]),
            .PSLVERR(pslverr[g])
        );
    end

    function automatic int wc(input int k);
        return (k == 0) ? 0 : ((k == 1) ? 2 : 3);
    endfunction

    // Reference: an access errs when misaligned or past the last word (or a strobed read).
    function automatic logic mdl_err(input logic wr, input logic [7:0] a, input logic [3:0] s);
        logic bad;
        bad = ((int'(a) % 4) != 0) || ((int'(a) / 4) >= DEPTH);
`ifdef APB_MEM_PSTRB_EN
        if (!wr && (s != 4'h0)) bad = 1'b1;
`else
        if (wr && (s == 4'h0)) bad = bad;
`endif
        return bad;
    endfunction

    function automatic void mdl_apply(input int k, input logic wr, input logic [7:0] a,
                                      input logic [31:0] d, input logic [3:0] s);
        logic bad;
        int   w;
        bad = mdl_err(wr, a, s);
        w   = int'(a) / 4;
        if (!wr) begin
            if (bad) mdl_prd[k] = 32'h0;
            else     mdl_prd[k] = mdl_mem[k][w];
        end else if (!bad) begin
            for (int b = 0; b < 4; b++) begin
`ifdef APB_MEM_PSTRB_EN
                if (s[b]) mdl_mem[k][w][8*b +: 8] = d[8*b +: 8];
`else
                mdl_mem[k][w][8*b +: 8] = d[8*b +: 8];
`endif
            end
        end
    endfunction

    function automatic void mdl_reset();
        for (int k = 0; k < N; k++) begin
            mdl_prd[k] = 32'h0;
            for (int i = 0; i < DEPTH; i++) mdl_mem[k][i] = 32'h0;
        end
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Drives the setup phase; returns just after the setup edge with PENABLE raised.
    task automatic start(input int k, input logic wr, input logic [7:0] a,
                         input logic [31:0] d, input logic [3:0] s);
        psel[k]    = 1'b1;
        penable[k] = 1'b0;
        pwrite[k]  = wr;
        paddr[k]   = a;
        pwdata[k]  = d;
        pstrb[k]   = s;
        @(posedge PCLK); #1;
        penable[k] = 1'b1;
    endtask

    // Waits (bounded) for PREADY, checks the access, releases the bus after completion.
    task automatic finish(input int k, input string tag, input int exp_waits,
                          input logic exp_err, input logic [31:0] exp_rd);
        int waits;
        waits = 0;
        while (waits < TMO) begin
            @(negedge PCLK);
            if (pready[k]) break;
            if (pslverr[k]) chk({tag, " pslverr-while-waiting"}, 32'(pslverr[k]), 32'h0);
            waits++;
        end
        chk({tag, " wait cycles"}, 32'(waits), 32'(exp_waits));
        chk({tag, " pslverr"}, 32'(pslverr[k]), 32'(exp_err));
        chk({tag, " prdata"}, prdata[k], exp_rd);
        @(posedge PCLK); #1;
        psel[k]    = 1'b0;
        penable[k] = 1'b0;
    endtask

    task automatic run(input int k, input string tag, input logic wr, input logic [7:0] a,
                       input logic [31:0] d, input logic [3:0] s,
                       input logic exp_err, input logic [31:0] exp_rd);
        start(k, wr, a, d, s);
        finish(k, tag, wc(k), exp_err, exp_rd);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int          k;
        logic        wr;
        logic [7:0]  a;
        logic [31:0] d;
        logic [3:0]  s;
        logic        e;

        tbl[0]  = '{0, 1'b1, 8'h0C, 32'hDEADBEEF, 4'hF, 1'b0, 32'h0};
        tbl[1]  = '{0, 1'b0, 8'h0C, 32'h0,        4'h0, 1'b0, 32'hDEADBEEF};
        tbl[2]  = '{2, 1'b1, 8'h04, 32'h12345678, 4'hF, 1'b0, 32'h0};
        tbl[3]  = '{2, 1'b0, 8'h04, 32'h0,        4'h0, 1'b0, 32'h12345678};
        tbl[4]  = '{2, 1'b1, 8'h0C, 32'h0BADF00D, 4'hF, 1'b0, 32'h12345678};
        tbl[5]  = '{0, 1'b1, 8'h40, 32'hFFFFFFFF, 4'hF, 1'b1, 32'hDEADBEEF};
        tbl[6]  = '{0, 1'b1, 8'h02, 32'hFFFFFFFF, 4'hF, 1'b1, 32'hDEADBEEF};
        tbl[7]  = '{0, 1'b0, 8'h40, 32'h0,        4'h0, 1'b1, 32'h0};
        tbl[8]  = '{0, 1'b0, 8'h00, 32'h0,        4'h0, 1'b0, 32'h0};
        tbl[9]  = '{0, 1'b0, 8'h0C, 32'h0,        4'h0, 1'b0, 32'hDEADBEEF};
        tbl[10] = '{1, 1'b1, 8'h08, 32'hCAFEF00D, 4'hF, 1'b0, 32'h0};
        tbl[11] = '{1, 1'b0, 8'h08, 32'h0,        4'h0, 1'b0, 32'hCAFEF00D};

        for (int i = 0; i < N; i++) begin
            psel[i] = 1'b0; penable[i] = 1'b0; pwrite[i] = 1'b0;
            paddr[i] = 8'h0; pwdata[i] = 32'h0; pstrb[i] = 4'h0;
        end
        mdl_reset();
        PRESETn = 1'b0;
        repeat (3) @(posedge PCLK);
        @(negedge PCLK);
        for (int i = 0; i < N; i++) begin
            chk($sformatf("reset pready[%0d]", i), 32'(pready[i]), 32'h0);
            chk($sformatf("reset pslverr[%0d]", i), 32'(pslverr[i]), 32'h0);
            chk($sformatf("reset prdata[%0d]", i), prdata[i], 32'h0);
        end
        @(posedge PCLK); #1;
        PRESETn = 1'b1;
        @(posedge PCLK); #1;

        // Directed table; consecutive rows on one instance run back to back.
        for (int i = 0; i < 12; i++) begin
            run(tbl[i].k, $sformatf("tbl%0d", i), tbl[i].wr, tbl[i].a, tbl[i].d, tbl[i].s,
                tbl[i].err, tbl[i].rd);
            mdl_apply(tbl[i].k, tbl[i].wr, tbl[i].a, tbl[i].d, tbl[i].s);
        end

        // Abort a 2-wait write after one wait cycle by dropping PENABLE with a new read setup.
        start(1, 1'b1, 8'h08, 32'hA5A5A5A5, 4'hF);
        @(negedge PCLK);
        chk("abort first wait pready", 32'(pready[1]), 32'h0);
        @(posedge PCLK); #1;
        penable[1] = 1'b0;
        pwrite[1]  = 1'b0;
        pstrb[1]   = 4'h0;
        @(negedge PCLK);
        chk("abort dropped pready", 32'(pready[1]), 32'h0);
        @(posedge PCLK); #1;
        penable[1] = 1'b1;
        finish(1, "abort reread", 2, 1'b0, 32'hCAFEF00D);
        mdl_apply(1, 1'b0, 8'h08, 32'h0, 4'h0);

        // Reset in the middle of a 3-wait read.
        start(2, 1'b0, 8'h04, 32'h0, 4'h0);
        @(negedge PCLK);
        PRESETn = 1'b0;
        #1;
        chk("midreset pready", 32'(pready[2]), 32'h0);
        chk("midreset pslverr", 32'(pslverr[2]), 32'h0);
        chk("midreset prdata", prdata[2], 32'h0);
        chk("midreset prdata k0", prdata[0], 32'h0);
        psel[2] = 1'b0; penable[2] = 1'b0;
        @(posedge PCLK); #1;
        PRESETn = 1'b1;
        mdl_reset();
        @(posedge PCLK); #1;
        run(2, "post-reset idx3", 1'b0, 8'h0C, 32'h0, 4'h0, 1'b0, 32'h0);
        mdl_apply(2, 1'b0, 8'h0C, 32'h0, 4'h0);

`ifdef APB_MEM_PSTRB_EN
        run(0, "strb full", 1'b1, 8'h04, 32'h11223344, 4'hF, 1'b0, mdl_prd[0]);
        mdl_apply(0, 1'b1, 8'h04, 32'h11223344, 4'hF);
        run(0, "strb 0101", 1'b1, 8'h04, 32'hAABBCCDD, 4'b0101, 1'b0, mdl_prd[0]);
        mdl_apply(0, 1'b1, 8'h04, 32'hAABBCCDD, 4'b0101);
        run(0, "strb readback", 1'b0, 8'h04, 32'h0, 4'h0, 1'b0, 32'h11BB33DD);
        mdl_apply(0, 1'b0, 8'h04, 32'h0, 4'h0);
        run(0, "strb on read", 1'b0, 8'h04, 32'h0, 4'b0001, 1'b1, 32'h0);
        mdl_apply(0, 1'b0, 8'h04, 32'h0, 4'b0001);
`endif

        // Randomized traffic against the reference model.
        for (int i = 0; i < 60; i++) begin
            k  = $urandom_range(0, N - 1);
            wr = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 5) == 0) a = 8'($urandom_range(0, 255));
            else                           a = 8'($urandom_range(0, DEPTH - 1) * 4);
            d  = $urandom;
            s  = wr ? 4'($urandom_range(0, 15)) : 4'h0;
            if (!wr && ($urandom_range(0, 7) == 0)) s = 4'($urandom_range(1, 15));
            e  = mdl_err(wr, a, s);
            mdl_apply(k, wr, a, d, s);
            run(k, $sformatf("rnd%0d", i), wr, a, d, s, e, mdl_prd[k]);
            if ($urandom_range(0, 2) == 0) begin
                @(posedge PCLK); #1;
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
